// File: rtl/tank_level_model.sv
// tank_level_model
//   Simulated tank-level source for the irrigation controller. The level
//   (0..3) drains while the sprinkler (Bs) or drip (Vs) runs and rises while
//   the refill valve (fill) is open. Time advances only on the 1 Hz strobe.
//
// Ports
//   clock          system clock (50 MHz), all state changes on rising edge
//   reset_n        asynchronous active-low reset
//   tick_1hz       one-cycle strobe, once per second
//   Bs, Vs, fill   sprinkler / drip / refill commands
//   level          registered tank level, 0 = empty, 3 = full
//   L, M, H        thermometer sensor lines decoded from level
//   Error          registered fault flag (Bs&&Vs, or dry run)
//   level_changed  one-cycle pulse on the edge where level changes
module tank_level_model #(
  parameter int ASP_PERIOD_S  = 300,
  parameter int DRIP_PERIOD_S = 600,
  parameter int FILL_PERIOD_S = 60,
  parameter int INIT_LEVEL    = 3
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       tick_1hz,
  input  logic       Bs,
  input  logic       Vs,
  input  logic       fill,
  output logic [1:0] level,
  output logic       L,
  output logic       M,
  output logic       H,
  output logic       Error,
  output logic       level_changed
);

  localparam int MAX_AD     = (ASP_PERIOD_S > DRIP_PERIOD_S) ? ASP_PERIOD_S : DRIP_PERIOD_S;
  localparam int MAX_PERIOD = (MAX_AD > FILL_PERIOD_S) ? MAX_AD : FILL_PERIOD_S;
  localparam int CNT_W      = (MAX_PERIOD > 2) ? $clog2(MAX_PERIOD) : 1;

  localparam logic [CNT_W-1:0] ASP_LAST  = CNT_W'(ASP_PERIOD_S - 1);
  localparam logic [CNT_W-1:0] DRIP_LAST = CNT_W'(DRIP_PERIOD_S - 1);
  localparam logic [CNT_W-1:0] FILL_LAST = CNT_W'(FILL_PERIOD_S - 1);
  localparam logic [1:0]       LEVEL_RST = 2'(INIT_LEVEL);

  typedef enum logic [2:0] {
    IDLE,
    FILL,
    ASP,
    DRIP,
    FAULT
  } mode_t;

  mode_t            mode_q;
  mode_t            mode_next;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_next;
  logic [CNT_W-1:0] period_last;
  logic [1:0]       level_next;
  logic             active;
  logic             mode_same;
  logic             dry_run;
  logic             period_event;
  logic             err_next;

  function automatic logic [1:0] sat_inc(input logic [1:0] lv);
    return (lv == 2'd3) ? lv : lv + 2'd1;
  endfunction

  function automatic logic [1:0] sat_dec(input logic [1:0] lv);
    return (lv == 2'd0) ? lv : lv - 2'd1;
  endfunction

  // Mode decode, highest priority first
  always_comb begin
    mode_next = IDLE;
    if (Bs && Vs)  mode_next = FAULT;
    else if (fill) mode_next = FILL;
    else if (Bs)   mode_next = ASP;
    else if (Vs)   mode_next = DRIP;
  end

  always_comb begin
    period_last = '0;
    active      = 1'b0;
    case (mode_next)
      FILL: begin period_last = FILL_LAST; active = 1'b1; end
      ASP:  begin period_last = ASP_LAST;  active = 1'b1; end
      DRIP: begin period_last = DRIP_LAST; active = 1'b1; end
      default: begin period_last = '0; active = 1'b0; end
    endcase
  end

  assign mode_same = (mode_next == mode_q);
  // Draining an empty tank: flag it and park the counter at zero.
  assign dry_run   = ((mode_next == ASP) || (mode_next == DRIP)) && (level == 2'd0);

  // A mode change restarts the period; a tick on that same edge is dropped.
  assign period_event = tick_1hz && mode_same && active && !dry_run &&
                        (cnt_q == period_last);

  always_comb begin
    cnt_next = cnt_q;
    if (!mode_same || !active || dry_run) cnt_next = '0;
    else if (tick_1hz)                    cnt_next = period_event ? '0 : cnt_q + CNT_W'(1);
  end

  always_comb begin
    level_next = level;
    if (period_event) level_next = (mode_next == FILL) ? sat_inc(level) : sat_dec(level);
  end

  assign err_next = (mode_next == FAULT) || dry_run;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      mode_q        <= IDLE;
      cnt_q         <= '0;
      level         <= LEVEL_RST;
      Error         <= 1'b0;
      level_changed <= 1'b0;
    end else begin
      mode_q        <= mode_next;
      cnt_q         <= cnt_next;
      level         <= level_next;
      Error         <= err_next;
      level_changed <= (level_next != level);
    end
  end

  assign L = (level >= 2'd1);
  assign M = (level >= 2'd2);
  assign H = (level == 2'd3);

endmodule

// File: tb/tb_tank_level_model.sv
module tb_tank_level_model;

  logic       clock;
  logic       reset_n;
  logic       tick_1hz;
  logic       Bs;
  logic       Vs;
  logic       fill;
  logic [1:0] level;
  logic       L;
  logic       M;
  logic       H;
  logic       Error;
  logic       level_changed;

  int chk_cnt  = 0;
  int pass_cnt = 0;
  int lc_count = 0;
  int lc_base;

  tank_level_model #(
    .ASP_PERIOD_S (5),
    .DRIP_PERIOD_S(10),
    .FILL_PERIOD_S(3),
    .INIT_LEVEL   (3)
  ) dut (
    .clock        (clock),
    .reset_n      (reset_n),
    .tick_1hz     (tick_1hz),
    .Bs           (Bs),
    .Vs           (Vs),
    .fill         (fill),
    .level        (level),
    .L            (L),
    .M            (M),
    .H            (H),
    .Error        (Error),
    .level_changed(level_changed)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Count level_changed pulses, sampled just after each rising edge.
  always @(posedge clock) begin
    #1;
    if (level_changed) lc_count++;
  end

  task automatic check(input string tag, input int got, input int exp);
    chk_cnt++;
    if (got == exp) pass_cnt++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  // One tick every 4 clocks; returns on a falling edge.
  task automatic tick_n(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clock) tick_1hz = 1'b1;
      @(negedge clock) tick_1hz = 1'b0;
      repeat (2) @(negedge clock);
    end
  endtask

  task automatic check_sensors(input string tag, input int lv);
    check({tag, "_level"}, int'(level), lv);
    check({tag, "_LMH"}, int'({L, M, H}), int'({lv >= 1, lv >= 2, lv == 3}));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    reset_n  = 1'b0;
    tick_1hz = 1'b0;
    Bs       = 1'b0;
    Vs       = 1'b0;
    fill     = 1'b0;
    repeat (3) @(negedge clock);
    check_sensors("rst", 3);
    check("rst_err", int'(Error), 0);
    check("rst_lc", int'(level_changed), 0);
    reset_n = 1'b1;

    // Idle: nothing moves
    lc_base = lc_count;
    tick_n(20);
    check_sensors("idle", 3);
    check("idle_lc", lc_count - lc_base, 0);

    // Sprinkler drain
    Bs = 1'b1;
    lc_base = lc_count;
    tick_n(4);
    check_sensors("asp_t4", 3);
    tick_n(1);
    check_sensors("asp_t5", 2);
    tick_n(5);
    check_sensors("asp_t10", 1);
    tick_n(5);
    check_sensors("asp_t15", 0);
    check("asp_lc", lc_count - lc_base, 3);
    check("asp_dry_err", int'(Error), 1);
    Bs = 1'b0;
    repeat (2) @(negedge clock);
    check("idle_err", int'(Error), 0);

    // Refill from empty to level 1, then drip to dry
    fill = 1'b1;
    tick_n(3);
    check_sensors("fill1", 1);
    fill = 1'b0;
    Vs   = 1'b1;
    tick_n(9);
    check_sensors("drip_t9", 1);
    @(negedge clock) tick_1hz = 1'b1;
    @(negedge clock) tick_1hz = 1'b0;
    check_sensors("drip_t10", 0);
    check("drip_err_same", int'(Error), 0);
    @(negedge clock);
    check("drip_err_next", int'(Error), 1);
    lc_base = lc_count;
    tick_n(12);
    check_sensors("dry", 0);
    check("dry_err", int'(Error), 1);
    check("dry_lc", lc_count - lc_base, 0);
    Vs = 1'b0;

    // Refill to full
    fill = 1'b1;
    tick_n(9);
    check_sensors("fill3", 3);
    fill = 1'b0;

    // Fault overlap, then fresh period for Bs
    Bs = 1'b1;
    tick_n(3);
    Vs = 1'b1;
    tick_n(4);
    check("fault_err", int'(Error), 1);
    check_sensors("fault", 3);
    Vs = 1'b0;
    tick_n(4);
    check("post_fault_err", int'(Error), 0);
    check_sensors("post_fault_t4", 3);
    tick_n(1);
    check_sensors("post_fault_t5", 2);

    // Reset mid-period, asserted between clock edges
    tick_n(4);
    check_sensors("pre_rst", 2);
    #2 reset_n = 1'b0;
    #1;
    check_sensors("async_rst", 3);
    check("async_rst_err", int'(Error), 0);
    check("async_rst_lc", int'(level_changed), 0);
    @(negedge clock) reset_n = 1'b1;
    tick_n(4);
    check_sensors("rel_t4", 3);
    tick_n(1);
    check_sensors("rel_t5", 2);
    tick_n(5);
    check_sensors("rel_t10", 1);

    // Refill with Bs still on: fill wins, saturates at 3
    fill = 1'b1;
    lc_base = lc_count;
    tick_n(3);
    check_sensors("sat_t3", 2);
    tick_n(3);
    check_sensors("sat_t6", 3);
    tick_n(6);
    check_sensors("sat_t12", 3);
    check("sat_lc", lc_count - lc_base, 2);
    check("sat_err", int'(Error), 0);
    fill = 1'b0;
    Bs   = 1'b0;
    repeat (2) @(negedge clock);

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
